// File: rtl/uart_fifo_port_if.sv
// uart_fifo_port_if: core-side bundle of FIFO handshakes, sticky error flags and occupancy levels.
interface uart_fifo_port_if #(
    parameter int DATA_BITS = 8,
    parameter int FIFO_AW   = 4
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 rx_overrun;
    logic                 err_clr;
    logic                 tx_busy;
    logic [FIFO_AW:0]     tx_level;
    logic [FIFO_AW:0]     rx_level;
    modport master (
        output tx_data, tx_valid, rx_ready, err_clr,
        input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun,
               tx_busy, tx_level, rx_level
    );
    modport slave (
        input  tx_data, tx_valid, rx_ready, err_clr,
        output tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun,
               tx_busy, tx_level, rx_level
    );
endinterface

// File: rtl/uart_fifo_port.sv
// uart_fifo_port: parametrised UART with TX/RX FIFOs, 8x-oversampled bit timing and sticky error flags.
module uart_fifo_port #(
    parameter int PRESCALE  = 54,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int FIFO_AW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rxd,
    output logic             txd,
    uart_fifo_port_if.slave  bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;
    logic [DATA_BITS-1:0] tx_mem [DEPTH];
    logic [DATA_BITS-1:0] rx_mem [DEPTH];
    logic [FIFO_AW:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
    logic tx_push, tx_pop, rx_push, rx_pop, tx_nempty, rx_full;
    state_t tx_st_q, tx_st_d, rx_st_q, rx_st_d;
    logic [15:0] tx_tick_q, tx_tick_d, rx_tick_q, rx_tick_d;
    logic [2:0] tx_ph_q, tx_ph_d, rx_ph_q, rx_ph_d;
    logic [3:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, tx_head;
    logic tx_par_q, tx_par_d, rx_par_q, rx_par_d, txd_q, txd_d;
    logic rx_s1_q, rx_s2_q, rx_prev_q;
    logic fe_q, pe_q, ov_q, good, set_fe, set_pe, set_ov;
    logic tx_tick_end, tx_bit_end, rx_tick_end, rx_mid, par_ok;
    assign bus.tx_level      = tx_wr_q - tx_rd_q;
    assign bus.rx_level      = rx_wr_q - rx_rd_q;
    assign bus.tx_ready      = ~bus.tx_level[FIFO_AW];
    assign bus.rx_valid      = |bus.rx_level;
    assign bus.rx_data       = rx_mem[rx_rd_q[FIFO_AW-1:0]];
    assign bus.tx_busy       = (tx_st_q != IDLE) || tx_nempty;
    assign bus.rx_frame_err  = fe_q;
    assign bus.rx_parity_err = pe_q;
    assign bus.rx_overrun    = ov_q;
    assign txd               = txd_q;
    assign tx_nempty   = |bus.tx_level;
    assign rx_full     = bus.rx_level[FIFO_AW];
    assign tx_push     = bus.tx_valid & bus.tx_ready;
    assign rx_pop      = bus.rx_valid & bus.rx_ready;
    assign tx_head     = tx_mem[tx_rd_q[FIFO_AW-1:0]];
    assign tx_tick_end = tx_tick_q == 16'(PRESCALE - 1);
    assign tx_bit_end  = tx_tick_end && tx_ph_q == 3'd7;
    assign rx_tick_end = rx_tick_q == 16'(PRESCALE - 1);
    assign rx_mid      = rx_tick_end && rx_ph_q == 3'd3;
    assign par_ok      = (PARITY == 0) || ((^rx_sh_q ^ rx_par_q) == (PARITY == 1));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the word.
    assign rx_push     = good && (!rx_full || rx_pop);
    assign set_ov      = good && rx_full && !rx_pop;
    always_comb begin
        tx_st_d   = tx_st_q;
        tx_tick_d = tx_tick_end ? 16'd0 : tx_tick_q + 16'd1;
        tx_ph_d   = tx_ph_q + {2'b00, tx_tick_end};
        tx_bit_d  = tx_bit_q;
        tx_sh_d   = tx_sh_q;
        tx_par_d  = tx_par_q;
        txd_d     = txd_q;
        tx_pop    = 1'b0;
        if (tx_st_q == IDLE || (tx_st_q == STOP && tx_bit_end && tx_bit_q == 4'(STOP_BITS - 1))) begin
            tx_pop  = tx_nempty;
            tx_st_d = tx_nempty ? START : IDLE;
            txd_d   = ~tx_nempty;
            if (tx_nempty) begin
                tx_tick_d = 16'd0;
                tx_ph_d   = 3'd0;
                tx_sh_d   = tx_head;
                tx_par_d  = ^tx_head ^ (PARITY == 1);
            end
        end else if (tx_bit_end) begin
            case (tx_st_q)
                START: begin
                    tx_st_d  = DATA;
                    txd_d    = tx_sh_q[0];
                    tx_sh_d  = tx_sh_q >> 1;
                    tx_bit_d = 4'd0;
                end
                DATA: begin
                    tx_st_d  = tx_bit_q != 4'(DATA_BITS - 1) ? DATA : (PARITY != 0 ? PAR : STOP);
                    txd_d    = tx_bit_q != 4'(DATA_BITS - 1) ? tx_sh_q[0] : (PARITY != 0 ? tx_par_q : 1'b1);
                    tx_sh_d  = tx_sh_q >> 1;
                    tx_bit_d = tx_bit_q != 4'(DATA_BITS - 1) ? tx_bit_q + 4'd1 : 4'd0;
                end
                PAR: begin
                    tx_st_d  = STOP;
                    txd_d    = 1'b1;
                    tx_bit_d = 4'd0;
                end
                default: tx_bit_d = tx_bit_q + 4'd1;
            endcase
        end
    end
    always_comb begin
        rx_st_d   = rx_st_q;
        rx_tick_d = rx_tick_end ? 16'd0 : rx_tick_q + 16'd1;
        rx_ph_d   = rx_ph_q + {2'b00, rx_tick_end};
        rx_bit_d  = rx_bit_q;
        rx_sh_d   = rx_sh_q;
        rx_par_d  = rx_par_q;
        good      = 1'b0;
        set_fe    = 1'b0;
        set_pe    = 1'b0;
        case (rx_st_q)
            IDLE: if (rx_prev_q && !rx_s2_q) begin
                rx_st_d   = START;
                rx_tick_d = 16'd0;
                rx_ph_d   = 3'd0;
            end
            START: if (rx_mid) begin
                rx_st_d  = rx_s2_q ? IDLE : DATA;
                rx_bit_d = 4'd0;
            end
            DATA: if (rx_mid) begin
                rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
                rx_bit_d = rx_bit_q + 4'd1;
                rx_st_d  = rx_bit_q != 4'(DATA_BITS - 1) ? DATA : (PARITY != 0 ? PAR : STOP);
            end
            PAR: if (rx_mid) begin
                rx_par_d = rx_s2_q;
                rx_st_d  = STOP;
            end
            // Frame error is reported alone; parity is only judged on a good stop bit.
            STOP: if (rx_mid) begin
                good    = rx_s2_q && par_ok;
                set_pe  = rx_s2_q && !par_ok;
                set_fe  = !rx_s2_q;
                rx_st_d = rx_s2_q ? IDLE : BRK;
            end
            BRK: rx_st_d = rx_s2_q ? IDLE : BRK;
            default: rx_st_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q[FIFO_AW-1:0]] <= bus.tx_data;
        if (rx_push) rx_mem[rx_wr_q[FIFO_AW-1:0]] <= rx_sh_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_q <= '0; tx_rd_q <= '0; rx_wr_q <= '0; rx_rd_q <= '0;
            tx_st_q <= IDLE; tx_tick_q <= '0; tx_ph_q <= '0; tx_bit_q <= '0;
            tx_sh_q <= '0; tx_par_q <= 1'b0; txd_q <= 1'b1;
            rx_st_q <= IDLE; rx_tick_q <= '0; rx_ph_q <= '0; rx_bit_q <= '0;
            rx_sh_q <= '0; rx_par_q <= 1'b0;
            rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_prev_q <= 1'b1;
            fe_q <= 1'b0; pe_q <= 1'b0; ov_q <= 1'b0;
        end else begin
            tx_wr_q <= tx_wr_q + (FIFO_AW+1)'(tx_push);
            tx_rd_q <= tx_rd_q + (FIFO_AW+1)'(tx_pop);
            rx_wr_q <= rx_wr_q + (FIFO_AW+1)'(rx_push);
            rx_rd_q <= rx_rd_q + (FIFO_AW+1)'(rx_pop);
            tx_st_q <= tx_st_d; tx_tick_q <= tx_tick_d; tx_ph_q <= tx_ph_d; tx_bit_q <= tx_bit_d;
            tx_sh_q <= tx_sh_d; tx_par_q <= tx_par_d; txd_q <= txd_d;
            rx_st_q <= rx_st_d; rx_tick_q <= rx_tick_d; rx_ph_q <= rx_ph_d; rx_bit_q <= rx_bit_d;
            rx_sh_q <= rx_sh_d; rx_par_q <= rx_par_d;
            rx_s1_q <= rxd; rx_s2_q <= rx_s1_q; rx_prev_q <= rx_s2_q;
            fe_q <= (fe_q & ~bus.err_clr) | set_fe;
            pe_q <= (pe_q & ~bus.err_clr) | set_pe;
            ov_q <= (ov_q & ~bus.err_clr) | set_ov;
        end
    end
endmodule

// File: tb/tb_uart_fifo_port.sv
// tb_uart_fifo_port: scoreboard bench; u_tx (no parity) loops txd back to rxd, u_rx (even parity) is driven by tasks.
module tb_uart_fifo_port;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_line = 1'b1;
    logic tx_line, rx_txd;
    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] rx_q[$];
    logic [7:0] lb_q[$];
    logic       tx_q[$];
    uart_fifo_port_if #(.DATA_BITS(8), .FIFO_AW(4)) tx_if (), rx_if ();
    uart_fifo_port #(.PRESCALE(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_AW(4)) u_tx (
        .clk(clk), .rst_n(rst_n), .rxd(tx_line), .txd(tx_line), .bus(tx_if)
    );
    uart_fifo_port #(.PRESCALE(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_AW(4)) u_rx (
        .clk(clk), .rst_n(rst_n), .rxd(rx_line), .txd(rx_txd), .bus(rx_if)
    );
    always #5 clk = ~clk;
    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end
    // Start, 8 data bits LSB first, even-parity bit (inverted when par_bad), stop; pop asserted at cycle pop_at.
    task automatic send_frame(input logic [7:0] d, input logic par_bad, input logic stop, input int pop_at);
        logic [10:0] f;
        f = {stop, (^d) ^ par_bad, d, 1'b0};
        @(negedge clk);
        for (int c = 0; c < 352; c++) begin
            rx_line = f[c/32];
            rx_if.rx_ready = (c == pop_at);
            @(negedge clk);
        end
        rx_line = 1'b1;
        rx_if.rx_ready = 1'b0;
    endtask
    task automatic pulse_clr();
        rx_if.err_clr = 1'b1;
        @(negedge clk);
        rx_if.err_clr = 1'b0;
        @(negedge clk);
    endtask
    task automatic drain_rx();
        logic [7:0] e;
        while (rx_q.size() > 0) begin
            e = rx_q.pop_front();
            n_chk++; if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== e) begin n_fail++; $display("FAIL rx_word got valid=%b data=%h want valid=1 data=%h", rx_if.rx_valid, rx_if.rx_data, e); end
            rx_if.rx_ready = 1'b1;
            @(negedge clk);
            rx_if.rx_ready = 1'b0;
        end
        n_chk++; if (rx_if.rx_valid !== 1'b0) begin n_fail++; $display("FAIL rx_empty got %b want 0", rx_if.rx_valid); end
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (tx_line !== 1'b1) begin n_fail++; $display("FAIL rst_txd got %b want 1", tx_line); end
        n_chk++; if (tx_if.tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_tx_ready got %b want 1", tx_if.tx_ready); end
        n_chk++; if (rx_if.rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rx_valid got %b want 0", rx_if.rx_valid); end
        n_chk++; if (tx_if.tx_level !== 5'd0 || rx_if.rx_level !== 5'd0) begin n_fail++; $display("FAIL rst_levels got %0d/%0d want 0/0", tx_if.tx_level, rx_if.rx_level); end
        n_chk++; if ({rx_if.rx_frame_err, rx_if.rx_parity_err, rx_if.rx_overrun} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b want 000", {rx_if.rx_frame_err, rx_if.rx_parity_err, rx_if.rx_overrun}); end
        n_chk++; if (tx_if.tx_busy !== 1'b0) begin n_fail++; $display("FAIL rst_tx_busy got %b want 0", tx_if.tx_busy); end
    endtask
    task automatic test_tx_frame();
        logic [9:0] f;
        logic e;
        f = {1'b1, 8'hA5, 1'b0};
        for (int b = 0; b < 10; b++) for (int c = 0; c < 32; c++) tx_q.push_back(f[b]);
        lb_q.push_back(8'hA5);
        @(negedge clk);
        tx_if.tx_data = 8'hA5;
        tx_if.tx_valid = 1'b1;
        @(negedge clk);
        tx_if.tx_valid = 1'b0;
        n_chk++; if (tx_line !== 1'b1) begin n_fail++; $display("FAIL tx_pop_cycle txd got %b want 1", tx_line); end
        @(negedge clk);
        for (int i = 0; tx_q.size() > 0; i++) begin
            e = tx_q.pop_front();
            n_chk++; if (tx_line !== e) begin n_fail++; $display("FAIL tx_bit cycle N+%0d got %b want %b", i + 2, tx_line, e); end
            if (tx_q.size() == 0) begin
                n_chk++; if (tx_if.tx_busy !== 1'b1) begin n_fail++; $display("FAIL tx_busy_stop got %b want 1", tx_if.tx_busy); end
            end
            @(negedge clk);
        end
        n_chk++; if (tx_if.tx_busy !== 1'b0 || tx_line !== 1'b1) begin n_fail++; $display("FAIL tx_after_stop got busy=%b txd=%b want busy=0 txd=1", tx_if.tx_busy, tx_line); end
        e = 1'b0;
        n_chk++; if (tx_if.rx_valid !== 1'b1 || tx_if.rx_data !== lb_q[0]) begin n_fail++; $display("FAIL loopback got valid=%b data=%h want valid=1 data=%h", tx_if.rx_valid, tx_if.rx_data, lb_q[0]); end
        void'(lb_q.pop_front());
        tx_if.rx_ready = 1'b1;
        @(negedge clk);
        tx_if.rx_ready = 1'b0;
    endtask
    task automatic test_rx_good();
        rx_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b0, 1'b1, -1);
        n_chk++; if (rx_if.rx_level !== 5'd1) begin n_fail++; $display("FAIL rx_good_level got %0d want 1", rx_if.rx_level); end
        n_chk++; if ({rx_if.rx_frame_err, rx_if.rx_parity_err, rx_if.rx_overrun} !== 3'b000) begin n_fail++; $display("FAIL rx_good_flags got %b want 000", {rx_if.rx_frame_err, rx_if.rx_parity_err, rx_if.rx_overrun}); end
        drain_rx();
    endtask
    task automatic test_parity_err();
        send_frame(8'h3C, 1'b1, 1'b1, -1);
        n_chk++; if (rx_if.rx_parity_err !== 1'b1 || rx_if.rx_frame_err !== 1'b0) begin n_fail++; $display("FAIL par_err got pe=%b fe=%b want pe=1 fe=0", rx_if.rx_parity_err, rx_if.rx_frame_err); end
        n_chk++; if (rx_if.rx_level !== 5'd0) begin n_fail++; $display("FAIL par_err_level got %0d want 0", rx_if.rx_level); end
        pulse_clr();
        n_chk++; if (rx_if.rx_parity_err !== 1'b0) begin n_fail++; $display("FAIL par_err_clr got %b want 0", rx_if.rx_parity_err); end
    endtask
    task automatic test_frame_err();
        send_frame(8'h55, 1'b0, 1'b0, -1);
        n_chk++; if (rx_if.rx_frame_err !== 1'b1 || rx_if.rx_parity_err !== 1'b0) begin n_fail++; $display("FAIL frame_err got fe=%b pe=%b want fe=1 pe=0", rx_if.rx_frame_err, rx_if.rx_parity_err); end
        n_chk++; if (rx_if.rx_level !== 5'd0) begin n_fail++; $display("FAIL frame_err_level got %0d want 0", rx_if.rx_level); end
        pulse_clr();
        n_chk++; if (rx_if.rx_frame_err !== 1'b0) begin n_fail++; $display("FAIL frame_err_clr got %b want 0", rx_if.rx_frame_err); end
    endtask
    task automatic test_overrun();
        for (int i = 0; i < 17; i++) begin
            if (i < 16) rx_q.push_back(8'(i));
            send_frame(8'(i), 1'b0, 1'b1, -1);
        end
        n_chk++; if (rx_if.rx_level !== 5'd16) begin n_fail++; $display("FAIL ovr_level got %0d want 16", rx_if.rx_level); end
        n_chk++; if (rx_if.rx_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got %b want 1", rx_if.rx_overrun); end
        n_chk++; if (rx_if.rx_data !== rx_q[0]) begin n_fail++; $display("FAIL ovr_head got %h want %h", rx_if.rx_data, rx_q[0]); end
        pulse_clr();
        // Pop lands on the stop-bit mid-sample cycle of this frame, so push and pop coincide at full.
        void'(rx_q.pop_front());
        rx_q.push_back(8'h11);
        send_frame(8'h11, 1'b0, 1'b1, 338);
        n_chk++; if (rx_if.rx_overrun !== 1'b0 || rx_if.rx_level !== 5'd16) begin n_fail++; $display("FAIL ovr_popfull got ov=%b level=%0d want ov=0 level=16", rx_if.rx_overrun, rx_if.rx_level); end
        drain_rx();
    endtask
    task automatic test_glitch();
        @(negedge clk);
        rx_line = 1'b0;
        repeat (8) @(negedge clk);
        rx_line = 1'b1;
        repeat (400) @(negedge clk);
        n_chk++; if (rx_if.rx_level !== 5'd0 || rx_if.rx_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_level got %0d want 0", rx_if.rx_level); end
        n_chk++; if ({rx_if.rx_frame_err, rx_if.rx_parity_err, rx_if.rx_overrun} !== 3'b000) begin n_fail++; $display("FAIL glitch_flags got %b want 000", {rx_if.rx_frame_err, rx_if.rx_parity_err, rx_if.rx_overrun}); end
    endtask
    task automatic test_reset_mid_tx();
        @(negedge clk);
        tx_if.tx_data = 8'h00;
        tx_if.tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        tx_if.tx_valid = 1'b0;
        repeat (50) @(negedge clk);
        n_chk++; if (tx_line !== 1'b0 || tx_if.tx_level !== 5'd2) begin n_fail++; $display("FAIL mid_tx got txd=%b level=%0d want txd=0 level=2", tx_line, tx_if.tx_level); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (tx_line !== 1'b1) begin n_fail++; $display("FAIL async_rst_txd got %b want 1", tx_line); end
        n_chk++; if (tx_if.tx_level !== 5'd0 || tx_if.tx_busy !== 1'b0) begin n_fail++; $display("FAIL async_rst_tx got level=%0d busy=%b want 0/0", tx_if.tx_level, tx_if.tx_busy); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        n_chk++; if (tx_line !== 1'b1 || tx_if.rx_level !== 5'd0) begin n_fail++; $display("FAIL post_rst got txd=%b rx_level=%0d want 1/0", tx_line, tx_if.rx_level); end
    endtask
    initial begin
        tx_if.tx_data = '0; tx_if.tx_valid = 1'b0; tx_if.rx_ready = 1'b0; tx_if.err_clr = 1'b0;
        rx_if.tx_data = '0; rx_if.tx_valid = 1'b0; rx_if.rx_ready = 1'b0; rx_if.err_clr = 1'b0;
        test_reset();
        test_tx_frame();
        test_rx_good();
        test_parity_err();
        test_frame_err();
        test_overrun();
        test_glitch();
        test_reset_mid_tx();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
